sb_config_ctrl: RTL and testbench

- Serial configuration controller for an array of NUM_SB switch boxes; each box takes a 6-bit dir and a 6-bit en control vector.
- Accepts a bit-serial configuration stream over a valid/ready handshake into a shadow register.
- Optionally checks parity, then applies the new configuration atomically with a one-cycle break-before-make blank so bidirectional buffers never drive against each other.
- Sits between the bitstream loader and the routing fabric's switch-box control inputs.

---
 rtl/sb_cfg_pkg.sv | 22 ++
 rtl/sb_cfg_shreg.sv | 32 +++
 rtl/sb_config_ctrl.sv | 124 ++++++++++++
 tb/tb_sb_config_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sb_cfg_pkg.sv
// Shared types and field layout for the switch-box configuration controller.
// Each box uses 12 config bits: en[5:0] in bits 11:6 and dir[5:0] in bits 5:0.
package sb_cfg_pkg;
  localparam int SB_CFG_W   = 12;
  localparam int SB_DIR_W   = 6;
  localparam int SB_EN_W    = 6;
  localparam int SB_DIR_OFS = 0;
  localparam int SB_EN_OFS  = 6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    PARITY = 3'd2,
    BLANK  = 3'd3,
    APPLY  = 3'd4,
    ERR    = 3'd5
  } sb_cfg_state_t;

  function automatic int sb_cfg_total(input int num_sb);
    return num_sb * SB_CFG_W;
  endfunction
endpackage

// File: rtl/sb_cfg_shreg.sv
// Shadow shift register: MSB-first serial load into the LSB, with a running
// XOR of every bit shifted in since the last clear.
module sb_cfg_shreg #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_shift,
  input  logic         i_bit,
  output logic [W-1:0] o_data,
  output logic         o_par
);
  logic [W-1:0] r_data;
  logic         r_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_par  <= 1'b0;
    end else if (i_clr) begin
      r_data <= '0;
      r_par  <= 1'b0;
    end else if (i_shift) begin
      r_data <= {r_data[W-2:0], i_bit};
      r_par  <= r_par ^ i_bit;
    end
  end

  assign o_data = r_data;
  assign o_par  = r_par;
endmodule

// File: rtl/sb_config_ctrl.sv
// Serial config loader for NUM_SB switch boxes with break-before-make apply.
// Define SB_CFG_PARITY_EN to require a trailing even-parity bit per load.
module sb_config_ctrl
  import sb_cfg_pkg::*;
#(
  parameter int NUM_SB = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       cfg_valid,
  input  logic                       cfg_bit,
  output logic                       cfg_ready,
  output logic [NUM_SB*SB_DIR_W-1:0] sb_dir,
  output logic [NUM_SB*SB_EN_W-1:0]  sb_en,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);
  localparam int TOTAL = sb_cfg_total(NUM_SB);
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  sb_cfg_state_t r_state, w_state_nxt;
  logic [CNT_W-1:0]           r_cnt;
  logic [NUM_SB*SB_DIR_W-1:0] r_sb_dir, w_dir_new;
  logic [NUM_SB*SB_EN_W-1:0]  r_sb_en, w_en_new;
  logic                       r_done;
  logic [TOTAL-1:0]           w_shadow;
  logic                       w_par;
  logic                       w_xfer, w_start_ok, w_shift, w_last, w_enter_blank;

  assign cfg_ready  = (r_state == LOAD) || (r_state == PARITY);
  assign w_xfer     = cfg_valid & cfg_ready;
  assign w_start_ok = (r_state == IDLE) & start;
  assign w_shift    = w_xfer & (r_state == LOAD);
  assign w_last     = w_shift & (r_cnt == LAST);

  sb_cfg_shreg #(.W(TOTAL)) u_shreg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_start_ok),
    .i_shift (w_shift),
    .i_bit   (cfg_bit),
    .o_data  (w_shadow),
    .o_par   (w_par)
  );

  for (genvar k = 0; k < NUM_SB; k++) begin : g_box
    assign w_dir_new[k*SB_DIR_W +: SB_DIR_W] = w_shadow[k*SB_CFG_W + SB_DIR_OFS +: SB_DIR_W];
    assign w_en_new[k*SB_EN_W +: SB_EN_W]    = w_shadow[k*SB_CFG_W + SB_EN_OFS +: SB_EN_W];
  end

`ifdef SB_CFG_PARITY_EN
  logic w_par_ok;
  // Even parity over data plus trailing bit.
  assign w_par_ok = ~(w_par ^ cfg_bit);
`else
  logic w_unused_par;
  assign w_unused_par = w_par;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (start) w_state_nxt = LOAD;
      LOAD: begin
        if (w_last) begin
`ifdef SB_CFG_PARITY_EN
          w_state_nxt = PARITY;
`else
          w_state_nxt = BLANK;
`endif
        end
      end
`ifdef SB_CFG_PARITY_EN
      PARITY: if (w_xfer) w_state_nxt = w_par_ok ? BLANK : ERR;
      ERR:    w_state_nxt = IDLE;
`endif
      BLANK: w_state_nxt = APPLY;
      APPLY: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Enables drop on the edge that enters BLANK; dir is held so no buffer
  // changes direction while still driving.
  assign w_enter_blank = (w_state_nxt == BLANK) && (r_state != BLANK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_sb_dir <= '0;
      r_sb_en  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == APPLY);
      if (w_start_ok)   r_cnt <= '0;
      else if (w_shift) r_cnt <= r_cnt + CNT_W'(1);
      if (w_enter_blank)           r_sb_en <= '0;
      else if (r_state == APPLY)   r_sb_en <= w_en_new;
      if (r_state == APPLY)        r_sb_dir <= w_dir_new;
    end
  end

`ifdef SB_CFG_PARITY_EN
  logic r_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_err <= 1'b0;
    else if (w_start_ok)       r_err <= 1'b0;
    else if (r_state == ERR)   r_err <= 1'b1;
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign sb_dir = r_sb_dir;
  assign sb_en  = r_sb_en;
  assign busy   = (r_state != IDLE);
  assign done   = r_done;
endmodule

// File: tb/tb_sb_config_ctrl.sv
// Directed table-driven bench for sb_config_ctrl with NUM_SB=2 (24-bit stream).
// Parity sequences are included when SB_CFG_PARITY_EN is defined.
module tb_sb_config_ctrl;
  localparam int NUM_SB = 2;
  localparam int TOTAL  = 24;
  localparam int OW     = 12;
`ifdef SB_CFG_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cfg_valid = 1'b0, cfg_bit = 1'b0;
  logic cfg_ready, busy, done, err;
  logic [OW-1:0] sb_dir, sb_en;

  int checks = 0, errors = 0, done_cnt = 0;
  logic [OW-1:0] cur_en = '0, cur_dir = '0;

  typedef struct {
    logic [23:0] data;
    bit          toggle;
    int          start_at;
    logic [11:0] en;
    logic [11:0] dir;
  } vec_t;
  vec_t tbl[7];

  sb_config_ctrl #(.NUM_SB(NUM_SB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .cfg_ready(cfg_ready), .sb_dir(sb_dir), .sb_en(sb_en), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b, output bit ok);
    bit x;
    ok = 1'b0;
    cfg_valid = 1'b1;
    cfg_bit = b;
    for (int n = 0; n < 40 && !ok; n++) begin
      x = cfg_ready;
      @(posedge clk); #1;
      ok = x;
    end
    cfg_valid = 1'b0;
  endtask

  task automatic stream(input logic [23:0] d, input bit toggle, input int start_at, input int nbits);
    bit ok;
    bit busy_ok = 1'b1;
    int nx = 0;
    for (int i = TOTAL - 1; i >= TOTAL - nbits; i--) begin
      if (toggle) begin
        cfg_valid = 1'b0;
        if (busy !== 1'b1) busy_ok = 1'b0;
        @(posedge clk); #1;
      end
      if ((TOTAL - 1 - i) == start_at) start = 1'b1;
      send_bit(d[i], ok);
      start = 1'b0;
      if (!ok) break;
      nx++;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    chk("busy_during_load", 32'(busy_ok), 32'd1);
    chk("transfer_count", nx, nbits);
  endtask

  // Entered at 1ns after edge E (last accepted bit).
  task automatic finish_ok(input logic [11:0] en, input logic [11:0] dir);
    chk("blank_en_E", 32'(sb_en), 32'h0);
    chk("blank_dir_E", 32'(sb_dir), 32'(cur_dir));
    chk("ready_low_E", 32'(cfg_ready), 32'h0);
    @(posedge clk); #1;
    chk("blank_en_E1", 32'(sb_en), 32'h0);
    chk("blank_dir_E1", 32'(sb_dir), 32'(cur_dir));
    chk("done_low_E1", 32'(done), 32'h0);
    @(posedge clk); #1;
    chk("apply_en", 32'(sb_en), 32'(en));
    chk("apply_dir", 32'(sb_dir), 32'(dir));
    chk("done_E2", 32'(done), 32'h1);
    chk("err_E2", 32'(err), 32'h0);
    @(posedge clk); #1;
    chk("done_pulse_end", 32'(done), 32'h0);
    chk("idle_after", 32'(busy), 32'h0);
    cur_en = en;
    cur_dir = dir;
  endtask

  task automatic run_load(input vec_t v);
    bit ok;
    pulse_start();
    stream(v.data, v.toggle, v.start_at, TOTAL);
    chk("ready_after_data", 32'(cfg_ready), 32'(PAR));
    if (PAR) begin
      send_bit(^v.data, ok);
      chk("parity_xfer", 32'(ok), 32'h1);
    end
    finish_ok(v.en, v.dir);
  endtask

  initial begin
    bit ok;
    int d0;
    tbl[0] = '{24'hA5C3F0, 1'b0, -1, 12'hA4F, 12'h730};
    tbl[1] = '{24'h123456, 1'b1, -1, 12'h111, 12'h8D6};
    tbl[2] = '{24'hA5C3F0, 1'b1, -1, 12'hA4F, 12'h730};
    tbl[3] = '{24'h800000, 1'b0, -1, 12'h800, 12'h000};
    tbl[4] = '{24'hFFFFFF, 1'b0, -1, 12'hFFF, 12'hFFF};
    tbl[5] = '{24'h000001, 1'b0, -1, 12'h000, 12'h001};
    tbl[6] = '{24'h123456, 1'b0, 10, 12'h111, 12'h8D6};

    #2;
    chk("rst_dir", 32'(sb_dir), 32'h0);
    chk("rst_en", 32'(sb_en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ready", 32'(cfg_ready), 32'h0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // Valid while idle must be ignored.
    cfg_valid = 1'b1;
    cfg_bit = 1'b1;
    chk("idle_ready", 32'(cfg_ready), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_en", 32'(sb_en), 32'h0);
    cfg_valid = 1'b0;

    for (int i = 0; i < 7; i++) run_load(tbl[i]);

    // Reset in the middle of a load.
    pulse_start();
    stream(24'hA5C3F0, 1'b0, -1, 10);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_en", 32'(sb_en), 32'h0);
    chk("mid_rst_dir", 32'(sb_dir), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_ready", 32'(cfg_ready), 32'h0);
    chk("mid_rst_err", 32'(err), 32'h0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    cur_en = '0;
    cur_dir = '0;
    run_load(tbl[0]);

    if (PAR) begin
      run_load(tbl[4]);
      d0 = done_cnt;
      pulse_start();
      stream(24'h000001, 1'b0, -1, TOTAL);
      send_bit(1'b0, ok);
      chk("bad_par_xfer", 32'(ok), 32'h1);
      chk("bad_par_en_kept", 32'(sb_en), 32'hFFF);
      @(posedge clk); #1;
      chk("bad_par_err", 32'(err), 32'h1);
      chk("bad_par_busy", 32'(busy), 32'h0);
      @(posedge clk); #1;
      chk("bad_par_err_sticky", 32'(err), 32'h1);
      chk("bad_par_en", 32'(sb_en), 32'hFFF);
      chk("bad_par_dir", 32'(sb_dir), 32'hFFF);
      chk("bad_par_no_done", done_cnt, d0);
      run_load(tbl[5]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
